// File: rtl/cond_unit_pkg.sv
// Shared encodings for the E-stage condition unit: ARM condition codes,
// NZCV bit positions and the FlagWrite field layout.
package cond_unit_pkg;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // FlagWrite[1] enables the N,Z pair; FlagWrite[0] enables the C,V pair.
  localparam int FW_NZ_BIT = 1;
  localparam int FW_CV_BIT = 0;

  localparam logic [1:0] FW_NONE = 2'b00;
  localparam logic [1:0] FW_CV   = 2'b01;
  localparam logic [1:0] FW_NZ   = 2'b10;
  localparam logic [1:0] FW_ALL  = 2'b11;

endpackage

// File: rtl/cond_unit_condcheck.sv
// Combinational ARM condition-field evaluator against an NZCV flag vector.
module condcheck
  import cond_unit_pkg::*;
(
  input  logic [3:0] cond_i,
  input  logic [3:0] flags_i,
  output logic       cond_ex_o
);

  logic n, z, c, v, ge;

  assign n  = flags_i[FLAG_N];
  assign z  = flags_i[FLAG_Z];
  assign c  = flags_i[FLAG_C];
  assign v  = flags_i[FLAG_V];
  assign ge = (n == v);

  always_comb begin
    cond_ex_o = 1'b0;
    case (cond_i)
      COND_EQ: cond_ex_o = z;
      COND_NE: cond_ex_o = ~z;
      COND_CS: cond_ex_o = c;
      COND_CC: cond_ex_o = ~c;
      COND_MI: cond_ex_o = n;
      COND_PL: cond_ex_o = ~n;
      COND_VS: cond_ex_o = v;
      COND_VC: cond_ex_o = ~v;
      COND_HI: cond_ex_o = c & ~z;
      COND_LS: cond_ex_o = ~c | z;
      COND_GE: cond_ex_o = ge;
      COND_LT: cond_ex_o = ~ge;
      COND_GT: cond_ex_o = ~z & ge;
      COND_LE: cond_ex_o = z | ~ge;
      COND_AL: cond_ex_o = 1'b1;
      // Reserved NV encoding never executes.
      default: cond_ex_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_unit.sv
// Execute-stage condition unit: NZCV register, condition gating of the
// E-stage write controls into the E/M register, and a squashed-instruction counter.
module cond_unit
  import cond_unit_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             ValidE,
  input  logic             StallE,
  input  logic             FlushE,
  input  logic [3:0]       CondE,
  input  logic [1:0]       FlagWriteE,
  input  logic [3:0]       ALUFlags,
  input  logic             PCSrcE,
  input  logic             RegWriteE,
  input  logic             MemWriteE,
  input  logic             BranchE,
  output logic             CondExE,
  output logic             BranchTakenE,
  output logic [3:0]       Flags,
  output logic             PCSrcM,
  output logic             RegWriteM,
  output logic             MemWriteM,
  output logic [CNT_W-1:0] SkipCount
);

  logic             live;
  logic             cond_ok;
  logic [3:0]       flags_q, flags_d;
  logic             pcsrc_q, pcsrc_d;
  logic             regwrite_q, regwrite_d;
  logic             memwrite_q, memwrite_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign live = ValidE & ~StallE & ~FlushE;

  // Checked against the registered flags, so an instruction's own flag
  // write never influences its own condition.
  condcheck u_condcheck (
    .cond_i    (CondE),
    .flags_i   (flags_q),
    .cond_ex_o (cond_ok)
  );

  assign CondExE      = live & cond_ok;
  assign BranchTakenE = BranchE & CondExE;

  always_comb begin
    flags_d    = flags_q;
    pcsrc_d    = (PCSrcE | BranchE) & CondExE;
    regwrite_d = RegWriteE & CondExE;
    memwrite_d = MemWriteE & CondExE;
    cnt_d      = cnt_q;
    if (FlagWriteE[FW_NZ_BIT] && CondExE) begin
      flags_d[FLAG_N] = ALUFlags[FLAG_N];
      flags_d[FLAG_Z] = ALUFlags[FLAG_Z];
    end
    if (FlagWriteE[FW_CV_BIT] && CondExE) begin
      flags_d[FLAG_C] = ALUFlags[FLAG_C];
      flags_d[FLAG_V] = ALUFlags[FLAG_V];
    end
    if (live && !cond_ok) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      flags_q    <= 4'b0000;
      pcsrc_q    <= 1'b0;
      regwrite_q <= 1'b0;
      memwrite_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      flags_q    <= flags_d;
      pcsrc_q    <= pcsrc_d;
      regwrite_q <= regwrite_d;
      memwrite_q <= memwrite_d;
      cnt_q      <= cnt_d;
    end
  end

  assign Flags     = flags_q;
  assign PCSrcM    = pcsrc_q;
  assign RegWriteM = regwrite_q;
  assign MemWriteM = memwrite_q;
  assign SkipCount = cnt_q;

endmodule
